uart_rx_ctrl: RTL

//  Sequencing controller for the 16x-oversampled UART receiver.
//  - Drives the receiver's enable and captures each valid frame; extracts the data byte and buffers it in a first-word-fall-through FIFO.
//  - Classifies receiver errors and forces a timed receiver re-arm after each error.
//  - Flags line-idle gaps so upper layers can delimit packets.

---
 rtl/uart_rx_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_ctrl.sv
// Sequencing controller for a 16x-oversampled UART receiver.
// It runs the receiver enable FSM, buffers received bytes in a FWFT FIFO, classifies errors and flags idle gaps.
module uart_rx_ctrl #(
  parameter int DEPTH          = 8,
  parameter int DATA_LSB       = 1,
  parameter int RECOVER_CYCLES = 32,
  parameter int TIMEOUT        = 2048
) (
  input  logic                       ctrl_Clk,
  input  logic                       i_Rst_n,
  input  logic                       i_go,
  input  logic                       i_clr,
  output logic                       o_rx_enable,
  input  logic                       i_rx_valid,
  input  logic [9:0]                 i_rx_byte,
  input  logic [2:0]                 i_rx_error,
  output logic [7:0]                 o_data,
  output logic                       o_data_valid,
  input  logic                       i_data_ready,
  output logic [$clog2(DEPTH+1)-1:0] o_fifo_count,
  output logic                       o_overflow,
  output logic [7:0]                 o_err_cnt,
  output logic [2:0]                 o_last_error,
  output logic                       o_idle,
  output logic [1:0]                 o_state
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int REC_W  = $clog2(RECOVER_CYCLES);
  localparam int IDLE_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    OFF     = 2'd0,
    ARM     = 2'd1,
    RUN     = 2'd2,
    RECOVER = 2'd3
  } state_t;

  state_t            state, next_state;
  logic [REC_W-1:0]  rec_cnt;
  logic [2:0]        prev_error;
  logic              err_event;
  logic              err_counted;
  logic              accept;
  logic              cap_valid;
  logic [7:0]        cap_byte;
  logic [7:0]        mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              full, do_push, do_pop, drop;
  logic [IDLE_W-1:0] idle_cnt;
  logic              idle_armed;
  logic              unused_frame_bits;

  assign unused_frame_bits = ^i_rx_byte;

  assign err_event   = (i_rx_error != 3'b000) && (prev_error == 3'b000);
  assign err_counted = err_event && ((state == RUN) || (state == RECOVER));
  assign accept      = i_rx_valid && (state == RUN);

  always_ff @(posedge ctrl_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state       <= OFF;
      o_rx_enable <= 1'b0;
      prev_error  <= 3'b000;
    end else begin
      state       <= next_state;
      o_rx_enable <= (next_state == ARM) || (next_state == RUN);
      prev_error  <= i_rx_error;
    end
  end

  // Dropping i_go overrides every other transition.
  always_comb begin
    next_state = state;
    case (state)
      OFF:     if (i_go) next_state = ARM;
      ARM:     next_state = RUN;
      RUN:     if (err_event) next_state = RECOVER;
      RECOVER: if (rec_cnt == '0) next_state = i_go ? ARM : OFF;
      default: next_state = OFF;
    endcase
    if (!i_go) next_state = OFF;
  end

  // Loaded with N-1 on entry so RECOVER lasts exactly RECOVER_CYCLES cycles.
  always_ff @(posedge ctrl_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      rec_cnt <= '0;
    end else if ((next_state == RECOVER) && (state != RECOVER)) begin
      rec_cnt <= REC_W'(RECOVER_CYCLES - 1);
    end else if ((state == RECOVER) && (rec_cnt != '0)) begin
      rec_cnt <= rec_cnt - 1'b1;
    end
  end

  always_ff @(posedge ctrl_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_err_cnt    <= 8'd0;
      o_last_error <= 3'b000;
    end else if (err_counted) begin
      if (o_err_cnt != 8'hFF) o_err_cnt <= o_err_cnt + 8'd1;
      o_last_error <= i_rx_error;
    end else if (i_clr) begin
      o_err_cnt    <= 8'd0;
      o_last_error <= 3'b000;
    end
  end

  // One capture stage between the receiver and the FIFO write port.
  always_ff @(posedge ctrl_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      cap_valid <= 1'b0;
      cap_byte  <= 8'd0;
    end else begin
      cap_valid <= accept;
      if (accept) cap_byte <= i_rx_byte[DATA_LSB +: 8];
    end
  end

  assign full         = (count == CNT_W'(DEPTH));
  assign o_data_valid = (count != '0);
  assign do_pop       = o_data_valid && i_data_ready;
  assign do_push      = cap_valid && (!full || do_pop);
  assign drop         = cap_valid && full && !do_pop;
  assign o_data       = o_data_valid ? mem[rd_ptr] : 8'd0;
  assign o_fifo_count = count;

  always_ff @(posedge ctrl_Clk) begin
    if (do_push) mem[wr_ptr] <= cap_byte;
  end

  always_ff @(posedge ctrl_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge ctrl_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_overflow <= 1'b0;
    end else if (drop) begin
      o_overflow <= 1'b1;
    end else if (i_clr) begin
      o_overflow <= 1'b0;
    end
  end

  // The counter parks at TIMEOUT-1 once reached; the armed flag makes the pulse one-shot.
  always_ff @(posedge ctrl_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      idle_cnt   <= '0;
      idle_armed <= 1'b0;
    end else if (state != RUN) begin
      idle_cnt   <= '0;
      idle_armed <= 1'b0;
    end else if (accept) begin
      idle_cnt   <= '0;
      idle_armed <= 1'b1;
    end else begin
      if (idle_cnt != IDLE_W'(TIMEOUT - 1)) idle_cnt <= idle_cnt + 1'b1;
      if (o_idle) idle_armed <= 1'b0;
    end
  end

  assign o_idle  = idle_armed && (idle_cnt == IDLE_W'(TIMEOUT - 1)) && (state == RUN);
  assign o_state = state;

endmodule
